// File: rtl/label_frame_stats_pkg.sv
// Shared definitions for the label stream: class encoding, frame geometry defaults and
// presence states used by the per-frame statistics block and the label generator.
package label_frame_stats_pkg;

  typedef enum logic [2:0] {
    LblRoad       = 3'd0,
    LblWalkRoad   = 3'd1,
    LblBackground = 3'd2,
    LblCar        = 3'd3,
    LblHuman      = 3'd4
  } label_e;

  typedef enum logic {
    PresAbsent  = 1'b0,
    PresPresent = 1'b1
  } presence_state_e;

  localparam int unsigned HActDefault = 320;
  localparam int unsigned VActDefault = 240;
  localparam int unsigned NumClasses  = 5;
  localparam int unsigned CwDefault   = $clog2(HActDefault * VActDefault + 1);

endpackage

// File: rtl/label_frame_stats_if.sv
// Pixel label stream in, per-frame ROI statistics and presence flags out.
interface label_frame_stats_if #(
  parameter int unsigned CW = label_frame_stats_pkg::CwDefault
);

  logic          pix_valid;
  logic [9:0]    pix_x;
  logic [8:0]    pix_y;
  logic [2:0]    label_data;

  logic          frame_done;
  logic [CW-1:0] road_cnt;
  logic [CW-1:0] walk_cnt;
  logic [CW-1:0] bg_cnt;
  logic [CW-1:0] car_cnt;
  logic [CW-1:0] human_cnt;
  logic          car_present;
  logic          human_present;

  modport master (
    output pix_valid, pix_x, pix_y, label_data,
    input  frame_done, road_cnt, walk_cnt, bg_cnt, car_cnt, human_cnt,
    input  car_present, human_present
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, label_data,
    output frame_done, road_cnt, walk_cnt, bg_cnt, car_cnt, human_cnt,
    output car_present, human_present
  );

endinterface

// File: rtl/label_frame_stats_presence_debounce.sv
// Debounces a per-frame "class seen" decision: the flag only toggles after PERSIST
// consecutive frames disagree with its current value.
module label_frame_stats_presence_debounce
  import label_frame_stats_pkg::*;
#(
  parameter int unsigned MIN_PIX = 2000,
  parameter int unsigned PERSIST = 3,
  parameter int unsigned CW      = 17
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          upd,
  input  logic [CW-1:0] cnt,
  output logic          present
);

  localparam int unsigned SW = $clog2(PERSIST + 1);
  localparam logic [0:0] StAbsent  = 1'(PresAbsent);
  localparam logic [0:0] StPresent = 1'(PresPresent);

  logic [0:0]    state_q, state_d;
  logic [SW-1:0] streak_q, streak_d, streak_inc;
  logic          hit, against;

  assign hit        = (cnt >= CW'(MIN_PIX));
  assign streak_inc = streak_q + SW'(1);
  // A frame that disagrees with the current state extends the streak toward a toggle.
  assign against    = (state_q == StAbsent) ? hit : !hit;

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    if (upd) begin
      if (against) begin
        if (streak_inc == SW'(PERSIST)) begin
          state_d  = ~state_q;
          streak_d = '0;
        end else begin
          streak_d = streak_inc;
        end
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StAbsent;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  assign present = (state_q == StPresent);

endmodule

// File: rtl/label_frame_stats.sv
// Accumulates per-class pixel counts inside a crosswalk ROI, publishes them at end of
// frame and drives debounced car / human presence flags.
module label_frame_stats
  import label_frame_stats_pkg::*;
#(
  parameter int unsigned H_ACT         = HActDefault,
  parameter int unsigned V_ACT         = VActDefault,
  parameter int unsigned ROI_X0        = 80,
  parameter int unsigned ROI_X1        = 239,
  parameter int unsigned ROI_Y0        = 60,
  parameter int unsigned ROI_Y1        = 179,
  parameter int unsigned CAR_MIN_PIX   = 2000,
  parameter int unsigned HUMAN_MIN_PIX = 500,
  parameter int unsigned PERSIST       = 3,
  parameter int unsigned CW            = $clog2(H_ACT * V_ACT + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  label_frame_stats_if.slave  bus
);

  logic [CW-1:0] cnt_q [NumClasses];
  logic [CW-1:0] cnt_d [NumClasses];
  logic [CW-1:0] pub_q [NumClasses];
  logic [CW-1:0] pub_d [NumClasses];
  logic          in_frame_q, in_frame_d;
  logic          frame_done_q, frame_done_d;

  logic in_roi, at_start, at_end, sof, eof, count_en;

  assign in_roi   = (bus.pix_x >= 10'(ROI_X0)) && (bus.pix_x <= 10'(ROI_X1)) &&
                    (bus.pix_y >= 9'(ROI_Y0))  && (bus.pix_y <= 9'(ROI_Y1));
  assign at_start = (bus.pix_x == '0) && (bus.pix_y == '0);
  assign at_end   = (bus.pix_x == 10'(H_ACT - 1)) && (bus.pix_y == 9'(V_ACT - 1));

  assign sof      = bus.pix_valid && at_start;
  // An end pixel only closes a frame that was actually opened since reset.
  assign eof      = bus.pix_valid && at_end && in_frame_q;
  assign count_en = bus.pix_valid && in_roi && (in_frame_q || sof) &&
                    (bus.label_data < 3'(NumClasses));

  always_comb begin
    cnt_d        = cnt_q;
    pub_d        = pub_q;
    in_frame_d   = in_frame_q;
    frame_done_d = 1'b0;
    if (sof) begin
      for (int unsigned i = 0; i < NumClasses; i++) begin
        cnt_d[i] = '0;
      end
      in_frame_d = 1'b1;
    end
    if (count_en) begin
      for (int unsigned i = 0; i < NumClasses; i++) begin
        if (bus.label_data == 3'(i)) begin
          cnt_d[i] = cnt_d[i] + CW'(1);
        end
      end
    end
    // Publish includes the end pixel itself.
    if (eof) begin
      pub_d        = cnt_d;
      frame_done_d = 1'b1;
      in_frame_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NumClasses; i++) begin
        cnt_q[i] <= '0;
        pub_q[i] <= '0;
      end
      in_frame_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      pub_q        <= pub_d;
      in_frame_q   <= in_frame_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.frame_done = frame_done_q;
  assign bus.road_cnt   = pub_q[int'(LblRoad)];
  assign bus.walk_cnt   = pub_q[int'(LblWalkRoad)];
  assign bus.bg_cnt     = pub_q[int'(LblBackground)];
  assign bus.car_cnt    = pub_q[int'(LblCar)];
  assign bus.human_cnt  = pub_q[int'(LblHuman)];

  label_frame_stats_presence_debounce #(
    .MIN_PIX (CAR_MIN_PIX),
    .PERSIST (PERSIST),
    .CW      (CW)
  ) u_car_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .upd     (frame_done_q),
    .cnt     (pub_q[int'(LblCar)]),
    .present (bus.car_present)
  );

  label_frame_stats_presence_debounce #(
    .MIN_PIX (HUMAN_MIN_PIX),
    .PERSIST (PERSIST),
    .CW      (CW)
  ) u_human_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .upd     (frame_done_q),
    .cnt     (pub_q[int'(LblHuman)]),
    .present (bus.human_present)
  );

endmodule
